// File: rtl/dac_code_streamer.sv
// DAC code streamer: a small FIFO of conversion codes drained onto a registered
// din bus at a programmable update rate, with an upd strobe and a sticky underrun flag.
module dac_code_streamer #(
  parameter int BITS  = 4,
  parameter int DEPTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [BITS-1:0]          s_data,
  input  logic                     en,
  input  logic [DIV_W-1:0]         div,
  input  logic                     clr_underrun,
  output logic [BITS-1:0]          din,
  output logic                     upd,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [BITS-1:0]  mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0]  din_q, din_d;
  logic             upd_q, upd_d;
  logic             underrun_q, underrun_d;

  logic full_s;
  logic empty_s;
  logic tick_s;
  logic push_s;
  logic pop_s;

  // Next-state logic. Pops see only the registered level, so a sample written
  // this cycle cannot leave before the following tick.
  always_comb begin
    full_s  = (level_q == FULL_LVL);
    empty_s = (level_q == {LW{1'b0}});
    tick_s  = en && (cnt_q == div);
    push_s  = s_valid && !full_s;
    pop_s   = tick_s && !empty_s;

    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    din_d      = din_q;
    upd_d      = 1'b0;
    underrun_d = underrun_q;

    // A count above a freshly lowered div runs on to all-ones and wraps naturally.
    if (!en) begin
      cnt_d = {DIV_W{1'b0}};
    end else if (tick_s) begin
      cnt_d = {DIV_W{1'b0}};
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      din_d    = mem_q[rd_ptr_q];
      upd_d    = 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
      din_d    = din_q;
      upd_d    = 1'b0;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Set has priority over clear.
    if (tick_s && empty_s) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
      cnt_q      <= {DIV_W{1'b0}};
      din_q      <= {BITS{1'b0}};
      upd_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      upd_q      <= upd_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_ready  = ~full_s;
  assign din      = din_q;
  assign upd      = upd_q;
  assign underrun = underrun_q;
  assign level    = level_q;

endmodule

// File: tb/tb_dac_code_streamer.sv
// Directed self-checking bench for dac_code_streamer (BITS=4, DEPTH=8, DIV_W=8).
module tb_dac_code_streamer;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic       en;
  logic [7:0] div;
  logic       clr_underrun;
  logic [3:0] din;
  logic       upd;
  logic       underrun;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;

  dac_code_streamer #(.BITS(4), .DEPTH(8), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .en(en), .div(div), .clr_underrun(clr_underrun), .din(din), .upd(upd),
    .underrun(underrun), .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] code);
    s_valid = 1'b1;
    s_data  = code;
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (din !== 4'h0) begin errors++; $display("FAIL rst_din got=%0h exp=0", din); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL rst_upd got=%0b exp=0", upd); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got=%0b exp=0", underrun); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%0b exp=1", s_ready); end
    rst_n = 1'b1;
    cyc();
    // Build up state: din=1, underrun set, level=5, upd high.
    push_one(4'h7);
    en = 1'b1; div = 8'd0;
    cyc();
    cyc();
    en = 1'b0;
    for (int c = 1; c <= 6; c++) push_one(4'(c));
    en = 1'b1;
    cyc();
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL pre_level got=%0d exp=5", level); end
    checks++; if (din !== 4'h1) begin errors++; $display("FAIL pre_din got=%0h exp=1", din); end
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL pre_upd got=%0b exp=1", upd); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL pre_underrun got=%0b exp=1", underrun); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (din !== 4'h0) begin errors++; $display("FAIL async_din got=%0h exp=0", din); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL async_upd got=%0b exp=0", upd); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL async_underrun got=%0b exp=0", underrun); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL async_level got=%0d exp=0", level); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL async_s_ready got=%0b exp=1", s_ready); end
    en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_ordered();
    logic [3:0] exp_din;
    logic       exp_upd;
    div = 8'd3;
    push_one(4'h3);
    push_one(4'hA);
    push_one(4'hF);
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL ord_level got=%0d exp=3", level); end
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      exp_upd = (i == 4) || (i == 8) || (i == 12);
      exp_din = (i < 4) ? 4'h0 : (i < 8) ? 4'h3 : (i < 12) ? 4'hA : 4'hF;
      checks++; if (upd !== exp_upd) begin errors++; $display("FAIL ord_upd c%0d got=%0b exp=%0b", i, upd, exp_upd); end
      checks++; if (din !== exp_din) begin errors++; $display("FAIL ord_din c%0d got=%0h exp=%0h", i, din, exp_din); end
      checks++; if (underrun !== (i >= 16)) begin errors++; $display("FAIL ord_underrun c%0d got=%0b", i, underrun); end
    end
    en = 1'b0;
    clr_underrun = 1'b1;
    cyc();
    clr_underrun = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ord_clr got=%0b exp=0", underrun); end
  endtask

  task automatic test_full();
    div = 8'd0;
    for (int c = 1; c <= 9; c++) begin
      s_valid = 1'b1;
      s_data  = 4'(c);
      cyc();
    end
    s_valid = 1'b0;
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level got=%0d exp=8", level); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got=%0b exp=0", s_ready); end
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      checks++; if (din !== 4'(i)) begin errors++; $display("FAIL full_din p%0d got=%0h exp=%0h", i, din, 4'(i)); end
      checks++; if (upd !== 1'b1) begin errors++; $display("FAIL full_upd p%0d got=%0b exp=1", i, upd); end
      if (i == 1) begin
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got=%0b exp=1", s_ready); end
      end
    end
    cyc();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL full_tail_upd got=%0b exp=0", upd); end
    checks++; if (din !== 4'h8) begin errors++; $display("FAIL full_tail_din got=%0h exp=8", din); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL full_tail_underrun got=%0b exp=1", underrun); end
    en = 1'b0;
    clr_underrun = 1'b1;
    cyc();
    clr_underrun = 1'b0;
  endtask

  task automatic test_simultaneous();
    div = 8'd0;
    en = 1'b1; s_valid = 1'b1; s_data = 4'h5;
    cyc();
    s_valid = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL sim_underrun got=%0b exp=1", underrun); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL sim_level got=%0d exp=1", level); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL sim_upd got=%0b exp=0", upd); end
    checks++; if (din !== 4'h8) begin errors++; $display("FAIL sim_din_hold got=%0h exp=8", din); end
    cyc();
    checks++; if (din !== 4'h5) begin errors++; $display("FAIL sim_pop_din got=%0h exp=5", din); end
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL sim_pop_upd got=%0b exp=1", upd); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL sim_pop_level got=%0d exp=0", level); end
    en = 1'b0;
    clr_underrun = 1'b1;
    cyc();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL sim_clr got=%0b exp=0", underrun); end
    en = 1'b1;
    cyc();
    en = 1'b0; clr_underrun = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL sim_set_wins got=%0b exp=1", underrun); end
    clr_underrun = 1'b1;
    cyc();
    clr_underrun = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL sim_clr2 got=%0b exp=0", underrun); end
  endtask

  task automatic test_wrap();
    int         sent;
    int         got;
    int         max_lvl;
    logic       acc;
    sent = 0; got = 0; max_lvl = 0;
    s_valid = 1'b1; s_data = 4'h0;
    cyc();
    sent = 1;
    en = 1'b1; div = 8'd1;
    for (int c = 0; c < 300 && got < 24; c++) begin
      if (sent < 24 && s_ready) begin
        s_valid = 1'b1;
        s_data  = 4'(sent);
      end else begin
        s_valid = 1'b0;
      end
      acc = s_valid;
      cyc();
      if (acc) sent++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      checks++; if (level > 4'd8) begin errors++; $display("FAIL wrap_bound c%0d got=%0d max=8", c, level); end
      if (upd) begin
        checks++; if (din !== 4'(got)) begin errors++; $display("FAIL wrap_order n%0d got=%0h exp=%0h", got, din, 4'(got)); end
        got++;
      end
      if (got == 24) en = 1'b0;
    end
    s_valid = 1'b0;
    en = 1'b0;
    checks++; if (got !== 24) begin errors++; $display("FAIL wrap_count got=%0d exp=24", got); end
    checks++; if (max_lvl !== 8) begin errors++; $display("FAIL wrap_max_level got=%0d exp=8", max_lvl); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL wrap_end_level got=%0d exp=0", level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL wrap_underrun got=%0b exp=0", underrun); end
  endtask

  task automatic test_enable_div();
    logic exp_upd;
    div = 8'd1;
    push_one(4'hC);
    push_one(4'hD);
    push_one(4'hE);
    en = 1'b1;
    cyc();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL en_first_upd got=%0b exp=0", upd); end
    cyc();
    checks++; if (upd !== 1'b1 || din !== 4'hC) begin errors++; $display("FAIL en_pop_c upd=%0b din=%0h exp upd=1 din=c", upd, din); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (upd !== 1'b0 || din !== 4'hC || level !== 4'd2) begin
        errors++; $display("FAIL en_hold c%0d upd=%0b din=%0h level=%0d exp 0/c/2", i, upd, din, level);
      end
    end
    en = 1'b1;
    cyc();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL en_resume_upd got=%0b exp=0", upd); end
    cyc();
    checks++; if (upd !== 1'b1 || din !== 4'hD) begin errors++; $display("FAIL en_pop_d upd=%0b din=%0h exp upd=1 din=d", upd, din); end
    en = 1'b0;
    push_one(4'h1);
    push_one(4'h2);
    div = 8'd7;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (upd !== 1'b0) begin errors++; $display("FAIL div_pre c%0d got=%0b exp=0", i, upd); end
    end
    div = 8'd2;
    for (int i = 1; i <= 260; i++) begin
      cyc();
      exp_upd = (i == 254) || (i == 257) || (i == 260);
      checks++; if (upd !== exp_upd) begin errors++; $display("FAIL div_upd c%0d got=%0b exp=%0b", i, upd, exp_upd); end
      if (i == 254) begin
        checks++; if (din !== 4'hE) begin errors++; $display("FAIL div_din_e got=%0h exp=e", din); end
      end
      if (i == 257) begin
        checks++; if (din !== 4'h1) begin errors++; $display("FAIL div_din_1 got=%0h exp=1", din); end
      end
      if (i == 260) begin
        checks++; if (din !== 4'h2) begin errors++; $display("FAIL div_din_2 got=%0h exp=2", din); end
      end
    end
    en = 1'b0;
  endtask

  initial begin
    s_valid = 1'b0; s_data = 4'h0; en = 1'b0; div = 8'd0; clr_underrun = 1'b0;
    test_reset();
    test_ordered();
    test_full();
    test_simultaneous();
    test_wrap();
    test_enable_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
